// File: rtl/pixel_stream_tx_pkg.sv
// pixel_stream_tx_pkg: shared video types, defaults and field indices
package pixel_stream_tx_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;
    localparam int H_ACTIVE_DEF  = 1280;
    localparam int V_ACTIVE_DEF  = 720;
    localparam int ERR_EARLY_EOL = 0;
    localparam int ERR_LATE_EOL  = 1;
    localparam int ERR_EARLY_SOF = 2;
    localparam int COLOR_W       = 8;
    localparam int PIXEL_W       = 3 * COLOR_W;
    localparam int X_W           = 11;
    localparam int Y_W           = 10;
endpackage

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: AXI-stream video to pixel+coordinate stream with frame tracking
module pixel_stream_tx
    import pixel_stream_tx_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [PIXEL_W-1:0] S_TDATA,
    input  logic               S_TVALID,
    output logic               S_TREADY,
    input  logic               S_TUSER,
    input  logic               S_TLAST,
    output logic [PIXEL_W-1:0] DATA_OUT,
    output logic               DATA_OUT_VALID,
    output logic [X_W-1:0]     X_VALUE,
    output logic [Y_W-1:0]     Y_VALUE,
    output logic               FRAME_DONE,
    output logic [15:0]        FRAME_COUNT,
    output logic [2:0]         ERR_FLAGS,
    input  logic               CLR_ERR
);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    state_t         state;
    logic [X_W-1:0] x, ex;
    logic [Y_W-1:0] y, ey;
    logic           acc, sof, emit, at_xl, line_end, frame_end;
    logic [2:0]     new_err;

    assign S_TREADY = enable;

    // decode the accepted pixel: its emitted coordinate, line/frame boundaries and error events
    always_comb begin
        acc       = S_TVALID && enable;
        sof       = acc && S_TUSER;
        emit      = acc && (S_TUSER || state == ACTIVE);
        ex        = sof ? '0 : x;
        ey        = sof ? '0 : y;
        at_xl     = ex == X_LAST;
        line_end  = S_TLAST || at_xl;
        frame_end = line_end && ey == Y_LAST;
        new_err   = '0;
        new_err[ERR_EARLY_EOL] = emit && S_TLAST && !at_xl;
        new_err[ERR_LATE_EOL]  = emit && at_xl && !S_TLAST;
        new_err[ERR_EARLY_SOF] = sof && state != IDLE;
    end

    // frame state machine, coordinate counters and registered pixel output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            x              <= '0;
            y              <= '0;
            DATA_OUT       <= '0;
            DATA_OUT_VALID <= 1'b0;
            X_VALUE        <= '0;
            Y_VALUE        <= '0;
            FRAME_DONE     <= 1'b0;
            FRAME_COUNT    <= '0;
            ERR_FLAGS      <= '0;
        end else begin
            ERR_FLAGS      <= (CLR_ERR ? 3'b000 : ERR_FLAGS) | new_err;
            DATA_OUT_VALID <= emit;
            FRAME_DONE     <= emit && frame_end;
            if (!enable) begin
                state <= IDLE;
                x     <= '0;
                y     <= '0;
            end else if (emit) begin
                DATA_OUT <= S_TDATA;
                X_VALUE  <= ex;
                Y_VALUE  <= ey;
                if (frame_end) begin
                    state       <= IDLE;
                    x           <= '0;
                    y           <= '0;
                    FRAME_COUNT <= FRAME_COUNT + 16'd1;
                end else if (line_end) begin
                    state <= (at_xl && !S_TLAST) ? DISCARD : ACTIVE;
                    x     <= '0;
                    y     <= ey + 1'b1;
                end else begin
                    state <= ACTIVE;
                    x     <= ex + 1'b1;
                    y     <= ey;
                end
            end else if (acc && state == DISCARD && S_TLAST) begin
                state <= ACTIVE;
            end
        end
    end
endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: scoreboard bench for pixel_stream_tx at 8x4
module tb_pixel_stream_tx;
    typedef struct packed {
        logic [23:0] data;
        logic [10:0] x;
        logic [9:0]  y;
        logic        fd;
    } exp_t;

    logic        clk = 0, reset_n = 0, enable = 1;
    logic [23:0] S_TDATA = '0;
    logic        S_TVALID = 0, S_TUSER = 0, S_TLAST = 0, CLR_ERR = 0;
    logic        S_TREADY, DATA_OUT_VALID, FRAME_DONE;
    logic [23:0] DATA_OUT;
    logic [10:0] X_VALUE;
    logic [9:0]  Y_VALUE;
    logic [15:0] FRAME_COUNT;
    logic [2:0]  ERR_FLAGS;

    int   vectors = 0, miscompares = 0, fd_seen = 0;
    logic [23:0] seq = 24'h100000;
    exp_t q[$];

    pixel_stream_tx #(.H_ACTIVE(8), .V_ACTIVE(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
        .S_TUSER(S_TUSER), .S_TLAST(S_TLAST),
        .DATA_OUT(DATA_OUT), .DATA_OUT_VALID(DATA_OUT_VALID),
        .X_VALUE(X_VALUE), .Y_VALUE(Y_VALUE), .FRAME_DONE(FRAME_DONE),
        .FRAME_COUNT(FRAME_COUNT), .ERR_FLAGS(ERR_FLAGS), .CLR_ERR(CLR_ERR)
    );

    always #5 clk = ~clk;

    // monitor: every presented pixel is popped and compared against the scoreboard
    always @(negedge clk) begin
        if (reset_n && DATA_OUT_VALID) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pixel got (%0d,%0d) data=%h, none expected", X_VALUE, Y_VALUE, DATA_OUT);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({DATA_OUT, X_VALUE, Y_VALUE, FRAME_DONE} !== e) begin
                    miscompares++;
                    $display("FAIL pixel got data=%h (%0d,%0d) fd=%b, want data=%h (%0d,%0d) fd=%b",
                             DATA_OUT, X_VALUE, Y_VALUE, FRAME_DONE, e.data, e.x, e.y, e.fd);
                end
            end
            if (FRAME_DONE) fd_seen++;
        end else if (reset_n && FRAME_DONE) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_done_without_valid got 1, want 0");
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic pix(input logic u, input logic l, input logic e,
                       input int ex, input int ey, input logic fd);
        seq = seq + 24'h010203;
        S_TDATA = seq; S_TVALID = 1; S_TUSER = u; S_TLAST = l;
        if (e) q.push_back('{seq, 11'(ex), 10'(ey), fd});
        @(posedge clk); #1;
        S_TVALID = 0; S_TUSER = 0; S_TLAST = 0;
    endtask

    task automatic run(input int y, input int x0, input int x1, input logic sof,
                       input logic eol, input logic fd_end);
        for (int x = x0; x <= x1; x++)
            pix(sof && x == x0, eol && x == x1, 1, x, y, fd_end && x == x1);
    endtask

    task automatic frame();
        for (int y = 0; y < 4; y++) run(y, 0, 7, y == 0, 1, y == 3);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int fd0;
        #12;
        check("reset_valid", DATA_OUT_VALID, 0);
        check("reset_xy", {X_VALUE, Y_VALUE}, 0);
        check("reset_data", DATA_OUT, 0);
        check("reset_count", FRAME_COUNT, 0);
        check("reset_err", ERR_FLAGS, 0);
        check("reset_ready", S_TREADY, 1);
        @(posedge clk); #1 reset_n = 1;
        idle(1);
        // clean frame
        frame(); idle(2);
        check("clean_count", FRAME_COUNT, 1);
        check("clean_err", ERR_FLAGS, 0);
        check("clean_fd", fd_seen, 1);
        // pixels without SOF in IDLE are dropped
        repeat (3) pix(0, 0, 0, 0, 0, 0);
        frame(); idle(2);
        check("drop_count", FRAME_COUNT, 2);
        // early EOL at (5,1) with a coincident CLR_ERR
        run(0, 0, 7, 1, 1, 0);
        run(1, 0, 4, 0, 0, 0);
        CLR_ERR = 1; pix(0, 1, 1, 5, 1, 0); CLR_ERR = 0;
        run(2, 0, 7, 0, 1, 0);
        run(3, 0, 7, 0, 1, 1); idle(2);
        check("early_eol_err", ERR_FLAGS, 3'b001);
        check("early_eol_count", FRAME_COUNT, 3);
        CLR_ERR = 1; idle(1); CLR_ERR = 0;
        check("clr_err", ERR_FLAGS, 0);
        // late EOL: 10 pixels on line 0, TLAST on the 10th
        run(0, 0, 7, 1, 0, 0);
        pix(0, 0, 0, 0, 0, 0);
        pix(0, 1, 0, 0, 0, 0);
        for (int y = 1; y < 4; y++) run(y, 0, 7, 0, 1, y == 3);
        idle(2);
        check("late_eol_err", ERR_FLAGS, 3'b010);
        check("late_eol_count", FRAME_COUNT, 4);
        CLR_ERR = 1; idle(1); CLR_ERR = 0;
        // early SOF at (3,2) restarts the frame
        fd0 = fd_seen;
        run(0, 0, 7, 1, 1, 0);
        run(1, 0, 7, 0, 1, 0);
        run(2, 0, 2, 0, 0, 0);
        pix(1, 0, 1, 0, 0, 0);
        run(0, 1, 7, 0, 1, 0);
        for (int y = 1; y < 4; y++) run(y, 0, 7, 0, 1, y == 3);
        idle(2);
        check("early_sof_err", ERR_FLAGS, 3'b100);
        check("early_sof_fd", fd_seen - fd0, 1);
        check("early_sof_count", FRAME_COUNT, 5);
        CLR_ERR = 1; idle(1); CLR_ERR = 0;
        check("clr_err2", ERR_FLAGS, 0);
        // enable low mid-frame returns to IDLE
        run(0, 0, 3, 1, 0, 0);
        enable = 0; idle(1);
        check("disable_ready", S_TREADY, 0);
        pix(0, 0, 0, 0, 0, 0);
        enable = 1;
        pix(0, 0, 0, 0, 0, 0);
        idle(1);
        check("disable_count", FRAME_COUNT, 5);
        // reset mid-frame at (4,1)
        run(0, 0, 7, 1, 1, 0);
        run(1, 0, 3, 0, 0, 0);
        idle(1);
        S_TDATA = 24'hABCDEF; S_TVALID = 1;
        #2 reset_n = 0;
        #1;
        check("mid_reset_valid", DATA_OUT_VALID, 0);
        check("mid_reset_count", FRAME_COUNT, 0);
        check("mid_reset_xy", {X_VALUE, Y_VALUE}, 0);
        S_TVALID = 0;
        idle(1); reset_n = 1; idle(1);
        repeat (2) pix(0, 0, 0, 0, 0, 0);
        frame(); idle(2);
        check("post_reset_count", FRAME_COUNT, 1);
        check("post_reset_err", ERR_FLAGS, 0);
        check("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
